// File: rtl/alu_sequencer_ctrl_pkg.sv
// Shared definitions for the accumulator-processor sequencer.
// Holds the opcode map (same codes the ALU uses), the FSM state
// encoding and the ACC input-mux select encodings.
package alu_sequencer_ctrl_pkg;

  // Opcodes, IR[7:4]. ALU opcodes double as alu_select codes.
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZ   = 4'b0110;
  localparam logic [3:0] OP_JC   = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_LDI  = 4'b1001;
  localparam logic [3:0] OP_SHFR = 4'b1011;
  localparam logic [3:0] OP_SHFL = 4'b1100;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  // ACC input mux selects.
  localparam logic [1:0] ACC_SRC_ALU = 2'b00;
  localparam logic [1:0] ACC_SRC_MEM = 2'b01;
  localparam logic [1:0] ACC_SRC_REG = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_IMM1   = 3'd5,
    ST_IMM2   = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

endpackage

// File: rtl/alu_sequencer_ctrl_if.sv
// Bus bundle between the sequencer and its memory/datapath.
// master: the sequencer. slave: program memory + ACC/REG datapath.
//
// Signalling: start is a single-cycle request sampled only in IDLE/HALT.
// mem_rd is a read strobe with no back-pressure: memory must present
// mem_rdata[mem_addr] in the cycle after the strobe. acc_load/reg_load
// are strobes telling the datapath to load at the end of the cycle in
// which they are high. state is a debug copy of the FSM state.
interface alu_sequencer_ctrl_if;
  import alu_sequencer_ctrl_pkg::*;

  logic       start;
  logic [7:0] mem_rdata;
  logic       alu_zero_flag;
  logic       alu_carry_out;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [3:0] alu_select;
  logic       acc_load;
  logic [1:0] acc_src;
  logic [3:0] reg_sel;
  logic       reg_load;
  logic       zero_flag;
  logic       carry_flag;
  logic       halted;
  logic       illegal_op;
  state_t     state;

  modport master (
    input  start, mem_rdata, alu_zero_flag, alu_carry_out,
    output mem_addr, mem_rd, alu_select, acc_load, acc_src, reg_sel,
           reg_load, zero_flag, carry_flag, halted, illegal_op, state
  );

  modport slave (
    output start, mem_rdata, alu_zero_flag, alu_carry_out,
    input  mem_addr, mem_rd, alu_select, acc_load, acc_src, reg_sel,
           reg_load, zero_flag, carry_flag, halted, illegal_op, state
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Opcode classifier: IR[7:4] -> instruction class flags.
// Ports: opcode in; is_alu, is_mov, is_imm, is_halt, is_illegal out.
// NOP asserts none of the flags.
module alu_seq_decode
  import alu_sequencer_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_mov,
  output logic       is_imm,
  output logic       is_halt,
  output logic       is_illegal
);
  always_comb begin
    is_alu     = 1'b0;
    is_mov     = 1'b0;
    is_imm     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_NOR, OP_SHFR, OP_SHFL: is_alu  = 1'b1;
      OP_MOVR, OP_MOVA:                         is_mov  = 1'b1;
      OP_JZ, OP_JC, OP_JMP, OP_LDI:             is_imm  = 1'b1;
      OP_HLT:                                   is_halt = 1'b1;
      OP_NOP:                                   is_illegal = 1'b0;
      default:                                  is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_sequencer_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit accumulator
// processor. Owns PC, IR and the registered Z/C flags; drives the ALU
// select and ACC/REG load strobes. All outputs are registered.
// Ports: clk, rst_n (async, active low), bus (alu_sequencer_ctrl_if.master).
module alu_sequencer_ctrl
  import alu_sequencer_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC       = 8'h00,
  parameter bit         START_ON_RESET = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_sequencer_ctrl_if.master bus
);
  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic       zero_q, carry_q;
  logic       mem_rd_q, acc_load_q, reg_load_q, halted_q, illegal_q;
  logic [3:0] alu_sel_q;
  logic [1:0] acc_src_q;

  logic [3:0] op;
  logic [3:0] dec_op;
  logic       is_alu, is_mov, is_imm, is_halt, is_illegal;
  logic       jump_taken;

  assign op = ir[7:4];

  // In FETCH2 the decoder looks at the byte arriving from memory so the
  // illegal-opcode pulse can be registered into the DECODE cycle;
  // everywhere else it decodes the held IR.
  assign dec_op = (state == ST_FETCH2) ? bus.mem_rdata[7:4] : op;

  alu_seq_decode u_decode (
    .opcode     (dec_op),
    .is_alu     (is_alu),
    .is_mov     (is_mov),
    .is_imm     (is_imm),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Conditional jumps test the registered flags, never the live ALU outputs.
  assign jump_taken = (op == OP_JMP) ||
                      ((op == OP_JZ) && zero_q) ||
                      ((op == OP_JC) && carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      acc_load_q <= 1'b0;
      reg_load_q <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      alu_sel_q  <= 4'b0000;
      acc_src_q  <= ACC_SRC_ALU;
    end else begin
      // Strobes are single-cycle unless re-asserted for the next state.
      mem_rd_q   <= 1'b0;
      acc_load_q <= 1'b0;
      reg_load_q <= 1'b0;
      illegal_q  <= 1'b0;
      alu_sel_q  <= 4'b0000;
      acc_src_q  <= ACC_SRC_ALU;
      case (state)
        ST_IDLE: begin
          if (bus.start || START_ON_RESET) begin
            state    <= ST_FETCH1;
            mem_rd_q <= 1'b1;
          end
        end
        ST_FETCH1: state <= ST_FETCH2;
        ST_FETCH2: begin
          ir        <= bus.mem_rdata;
          pc        <= pc + 8'd1;
          illegal_q <= is_illegal;
          state     <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_alu) begin
            state      <= ST_EXEC;
            alu_sel_q  <= op;
            acc_load_q <= 1'b1;
            acc_src_q  <= ACC_SRC_ALU;
          end else if (is_mov) begin
            state <= ST_EXEC;
            if (op == OP_MOVR) begin
              acc_load_q <= 1'b1;
              acc_src_q  <= ACC_SRC_REG;
            end else begin
              reg_load_q <= 1'b1;
            end
          end else if (is_imm) begin
            state    <= ST_IMM1;
            mem_rd_q <= 1'b1;
          end else if (is_halt) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            // NOP and undefined opcodes both fall straight back to fetch.
            state    <= ST_FETCH1;
            mem_rd_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (is_alu) begin
            zero_q  <= bus.alu_zero_flag;
            carry_q <= bus.alu_carry_out;
          end
          state    <= ST_FETCH1;
          mem_rd_q <= 1'b1;
        end
        ST_IMM1: begin
          state <= ST_IMM2;
          if (op == OP_LDI) begin
            acc_load_q <= 1'b1;
            acc_src_q  <= ACC_SRC_MEM;
          end
        end
        ST_IMM2: begin
          pc       <= jump_taken ? bus.mem_rdata : pc + 8'd1;
          state    <= ST_FETCH1;
          mem_rd_q <= 1'b1;
        end
        ST_HALT: begin
          if (bus.start) begin
            state    <= ST_FETCH1;
            halted_q <= 1'b0;
            mem_rd_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = pc;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.alu_select = alu_sel_q;
  assign bus.acc_load   = acc_load_q;
  assign bus.acc_src    = acc_src_q;
  assign bus.reg_sel    = ir[3:0];
  assign bus.reg_load   = reg_load_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.halted     = halted_q;
  assign bus.illegal_op = illegal_q;
  assign bus.state      = state;
endmodule
